// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a MEM-stage port onto one shared memory port, with access timeout.
// Optional macro DMEM_FAIR_ARB_EN: alternate grants when both requesters contend (default: fixed D priority).
module mem_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_read,
   input  logic [31:0] i_addr,
   output logic [31:0] i_readdata,
   output logic        i_busywait,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_writedata,
   output logic [31:0] d_readdata,
   output logic        d_busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait,
   output logic        mem_timeout
);

   // state  | meaning
   // IDLE   | no access in flight; arbitrate pending requests
   // ACCESS | memory port owned by the latched requester until completion or timeout
   localparam logic [0:0]       ST_IDLE   = 1'b0;
   localparam logic [0:0]       ST_ACCESS = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [0:0]       state;
   logic             owner_d;
   logic [CNT_W-1:0] cnt;
   logic             done_i;
   logic             done_d;
   logic             d_req;
   logic             elig_i;
   logic             elig_d;
   logic             prefer_i;
   logic             grant_i;
   logic             grant_d;
   logic             in_access;
   logic             entry_cycle;
   logic             finish_ok;
   logic             finish_to;
   logic             finish;

`ifdef DMEM_FAIR_ARB_EN
   logic last_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_d <= 1'b0;
      end else if (grant_d) begin
         last_d <= 1'b1;
      end else if (grant_i) begin
         last_d <= 1'b0;
      end
   end

   assign prefer_i = last_d;
`else
   assign prefer_i = 1'b0;
`endif

   assign d_req       = d_read | d_write;
   assign in_access   = (state == ST_ACCESS);
   // cnt is zero only in the first ACCESS cycle, whose busywait is not trusted
   assign entry_cycle = (cnt == '0);

   // a requester is not regranted in the cycle it sees its done pulse
   assign elig_i  = i_read & ~done_i;
   assign elig_d  = d_req & ~done_d;
   assign grant_d = ~in_access & elig_d & ~(elig_i & prefer_i);
   assign grant_i = ~in_access & elig_i & ~grant_d;

   assign finish_ok = in_access & ~entry_cycle & ~mem_busywait;
   assign finish_to = in_access & ~finish_ok & (cnt == CNT_LAST);
   assign finish    = finish_ok | finish_to;

   assign i_busywait = i_read & ~done_i;
   assign d_busywait = d_req & ~done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         owner_d       <= 1'b0;
         cnt           <= '0;
         done_i        <= 1'b0;
         done_d        <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_addr      <= '0;
         mem_writedata <= '0;
         i_readdata    <= '0;
         d_readdata    <= '0;
         mem_timeout   <= 1'b0;
      end else begin
         done_i <= 1'b0;
         done_d <= 1'b0;
         if (grant_d) begin
            state         <= ST_ACCESS;
            owner_d       <= 1'b1;
            cnt           <= '0;
            mem_read      <= d_read;
            mem_write     <= d_write;
            mem_addr      <= d_addr;
            mem_writedata <= d_writedata;
         end else if (grant_i) begin
            state         <= ST_ACCESS;
            owner_d       <= 1'b0;
            cnt           <= '0;
            mem_read      <= 1'b1;
            mem_write     <= 1'b0;
            mem_addr      <= i_addr;
            mem_writedata <= '0;
         end else if (finish) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (owner_d) begin
               done_d <= 1'b1;
            end else begin
               done_i <= 1'b1;
            end
            // mem_read still holds the latched access type; stores leave readdata alone
            if (mem_read) begin
               if (owner_d) begin
                  d_readdata <= finish_to ? '0 : mem_readdata;
               end else begin
                  i_readdata <= finish_to ? '0 : mem_readdata;
               end
            end
            if (finish_to) begin
               mem_timeout <= 1'b1;
            end
         end else if (in_access) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle, directed scenarios, random traffic.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 1023;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_read = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_readdata;
   logic        i_busywait;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_writedata = '0;
   logic [31:0] d_readdata;
   logic        d_busywait;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;
   logic        mem_busywait = 1'b0;
   logic        mem_timeout;

   int n_chk = 0;
   int n_err = 0;

   mem_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(10)) dut (
      .clk(clk), .reset(rst),
      .i_read(i_read), .i_addr(i_addr), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_writedata(d_writedata),
      .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one in-flight transaction record plus per-requester results.
   bit          m_on = 1'b0;
   bit          m_busy, m_own_d, m_wr, m_done_i, m_done_d, m_tmo, m_last_d;
   logic [31:0] m_addr, m_wdata, m_ird, m_drd;
   int          m_k;
   bit          fin_ok, fin_to, e_i, e_d, take_d;

   always @(negedge clk) begin
      if (m_on) begin
         chk("mem_read", 32'(mem_read), 32'(m_busy && !m_wr));
         chk("mem_write", 32'(mem_write), 32'(m_busy && m_wr));
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_writedata", mem_writedata, m_wdata);
         chk("i_readdata", i_readdata, m_ird);
         chk("d_readdata", d_readdata, m_drd);
         chk("i_busywait", 32'(i_busywait), 32'(i_read && !m_done_i));
         chk("d_busywait", 32'(d_busywait), 32'((d_read || d_write) && !m_done_d));
         chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
      end
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_own_d = 1'b0; m_wr = 1'b0;
         m_done_i = 1'b0; m_done_d = 1'b0; m_tmo = 1'b0; m_last_d = 1'b0;
         m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0; m_k = 0;
      end else if (m_on) begin
         if (m_busy) begin
            // m_k is the 1-based index of the current ACCESS cycle
            fin_ok = (m_k >= 2) && !mem_busywait;
            fin_to = !fin_ok && (m_k == TIMEOUT);
            if (fin_ok || fin_to) begin
               if (!m_wr) begin
                  if (m_own_d) m_drd = fin_to ? 32'h0 : mem_readdata;
                  else         m_ird = fin_to ? 32'h0 : mem_readdata;
               end
               if (fin_to) m_tmo = 1'b1;
               m_done_d = m_own_d;
               m_done_i = !m_own_d;
               m_busy   = 1'b0;
            end else begin
               m_k++;
            end
         end else begin
            e_i = i_read && !m_done_i;
            e_d = (d_read || d_write) && !m_done_d;
            m_done_i = 1'b0;
            m_done_d = 1'b0;
`ifdef DMEM_FAIR_ARB_EN
            take_d = e_d && !(e_i && m_last_d);
`else
            take_d = e_d;
`endif
            if (take_d) begin
               m_busy = 1'b1; m_own_d = 1'b1; m_wr = d_write;
               m_addr = d_addr; m_wdata = d_writedata; m_k = 1; m_last_d = 1'b1;
            end else if (e_i) begin
               m_busy = 1'b1; m_own_d = 1'b0; m_wr = 1'b0;
               m_addr = i_addr; m_wdata = 32'h0; m_k = 1; m_last_d = 1'b0;
            end
         end
      end
   end

   // Memory responder: busy for the first lat_cur ACCESS cycles, or held busy on request.
   bit          hold_busy = 1'b0;
   bit          force_data_en = 1'b0;
   int          force_lat = -1;
   logic [31:0] force_data = '0;
   int          lat_cur = 0;

   always begin
      @(posedge clk);
      #1;
      if (hold_busy) begin
         mem_busywait = 1'b1;
      end else if (m_on && m_busy) begin
         if (m_k == 1) begin
            lat_cur = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
            mem_readdata = force_data_en ? force_data : $urandom;
         end
         mem_busywait = (m_k <= lat_cur);
      end else begin
         mem_busywait = ($urandom % 2) == 1;
         mem_readdata = $urandom;
      end
   end

   int          rd_cnt, c_done, w_first, r_first, n_iss, dd_cnt, to_drop, op;
   bit          dd, id, to_seen, prev_rd, ib, db;
   logic [31:0] w_addr, w_data;
   logic [31:0] iss [2];

   initial begin
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mem_read", 32'(mem_read), 32'h0);
      chk("reset_mem_write", 32'(mem_write), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_i_readdata", i_readdata, 32'h0);
      chk("reset_d_readdata", d_readdata, 32'h0);
      chk("reset_mem_timeout", 32'(mem_timeout), 32'h0);

      // single fetch, 3 busy cycles
      step();
      i_read = 1'b1; i_addr = 32'h40; force_lat = 3;
      force_data_en = 1'b1; force_data = 32'h00C0FFEE;
      rd_cnt = 0; c_done = -1; dd_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_read) rd_cnt++;
         id = i_read && !i_busywait;
         if (id) begin dd_cnt++; c_done = c; end
         step();
         if (id) i_read = 1'b0;
      end
      chk("fetch_mem_read_cycles", 32'(rd_cnt), 32'd4);
      chk("fetch_done_cycle", 32'(c_done), 32'd5);
      chk("fetch_busywait_low_cycles", 32'(dd_cnt), 32'd1);
      chk("fetch_readdata", i_readdata, 32'h00C0FFEE);

      // simultaneous fetch and store: store first, fetch granted in the store's done cycle
      i_read = 1'b1; i_addr = 32'h80; d_write = 1'b1; d_addr = 32'h100;
      d_writedata = 32'hA5A5A5A5; force_lat = 0; force_data = 32'h11112222;
      w_first = -1; r_first = -1; w_addr = '0; w_data = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_write && w_first < 0) begin w_first = c; w_addr = mem_addr; w_data = mem_writedata; end
         if (mem_read && r_first < 0) r_first = c;
         dd = d_write && !d_busywait;
         id = i_read && !i_busywait;
         step();
         if (dd) d_write = 1'b0;
         if (id) i_read = 1'b0;
      end
      chk("arb_write_first_cycle", 32'(w_first), 32'd1);
      chk("arb_write_addr", w_addr, 32'h100);
      chk("arb_write_data", w_data, 32'hA5A5A5A5);
      chk("arb_fetch_first_cycle", 32'(r_first), 32'd4);
      chk("arb_fetch_readdata", i_readdata, 32'h11112222);
      chk("arb_store_keeps_d_readdata", d_readdata, 32'h0);

      // back-to-back loads with d_read held across the done cycle
      d_read = 1'b1; d_addr = 32'h200; force_data = 32'h5EED0200;
      n_iss = 0; dd_cnt = 0; prev_rd = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_read && !prev_rd) begin
            if (n_iss < 2) iss[n_iss] = mem_addr;
            n_iss++;
         end
         prev_rd = mem_read;
         dd = d_read && !d_busywait;
         if (dd) dd_cnt++;
         step();
         if (dd && dd_cnt == 1) begin d_addr = 32'h204; force_data = 32'h5EED0204; end
         if (dd && dd_cnt == 2) d_read = 1'b0;
      end
      chk("b2b_issue_count", 32'(n_iss), 32'd2);
      chk("b2b_first_addr", iss[0], 32'h200);
      chk("b2b_second_addr", iss[1], 32'h204);
      chk("b2b_readdata", d_readdata, 32'h5EED0204);
      force_data_en = 1'b0; force_lat = -1;

      // timeout on a load with memory stuck busy
      d_read = 1'b1; d_addr = 32'h400; hold_busy = 1'b1;
      rd_cnt = 0; to_seen = 1'b0; to_drop = 0; dd_cnt = 0;
      for (int c = 0; c < 1100; c++) begin
         @(negedge clk);
         if (mem_read) rd_cnt++;
         if (mem_timeout) to_seen = 1'b1;
         else if (to_seen) to_drop++;
         dd = d_read && !d_busywait;
         if (dd) dd_cnt++;
         step();
         if (dd) d_read = 1'b0;
      end
      hold_busy = 1'b0;
      chk("timeout_access_cycles", 32'(rd_cnt), 32'd1023);
      chk("timeout_done_pulses", 32'(dd_cnt), 32'd1);
      chk("timeout_readdata", d_readdata, 32'h0);
      chk("timeout_flag", 32'(mem_timeout), 32'h1);
      chk("timeout_sticky", 32'(to_drop), 32'd0);

      // reset on the second ACCESS cycle of a store
      d_write = 1'b1; d_addr = 32'h300; d_writedata = 32'h1234; hold_busy = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("rst_abort_entry_write", 32'(mem_write), 32'h1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_abort_second_write", 32'(mem_write), 32'h1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_abort_write_low", 32'(mem_write), 32'h0);
      chk("rst_abort_no_done", 32'(d_busywait), 32'h1);
      chk("rst_clears_timeout", 32'(mem_timeout), 32'h0);
      step();
      d_write = 1'b0; hold_busy = 1'b0;
      repeat (4) step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ib = i_busywait;
         db = d_busywait;
         step();
         if (i_read) begin
            if (!ib) begin i_read = ($urandom % 2) == 1; i_addr = $urandom; end
            else if ($urandom_range(0, 19) == 0) i_addr = $urandom;
         end else if ($urandom_range(0, 2) == 0) begin
            i_read = 1'b1; i_addr = $urandom;
         end
         if (d_read || d_write) begin
            if (!db) begin
               op = int'($urandom_range(0, 2));
               d_read = (op == 1); d_write = (op == 2);
               d_addr = $urandom; d_writedata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
               d_addr = $urandom; d_writedata = $urandom;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            op = int'($urandom_range(1, 2));
            d_read = (op == 1); d_write = (op == 2);
            d_addr = $urandom; d_writedata = $urandom;
         end
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
